// File: rtl/uart_word_tx_sequencer.sv
// Word-to-byte sequencer in front of an 8-bit UART transmitter.
// Queues whole words in a small FIFO and sends each one MSB byte first.
// It issues one start pulse per byte and waits for the UART's done pulse
// before the next byte. All outputs come from registered state only.
module uart_word_tx_sequencer #(
    parameter int NBITS      = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  word_valid,
    input  logic [NBITS-1:0]      word_data,
    output logic                  word_ready,
    output logic [BYTE_WIDTH-1:0] uart_tx_data,
    output logic                  uart_tx_start,
    input  logic                  uart_tx_done,
    output logic                  word_done,
    output logic                  busy
);
    localparam int NB = NBITS / BYTE_WIDTH;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0]      LAST_IDX = IW'(NB - 1);
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t                 state;
    logic [NBITS-1:0]       mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]     wr_ptr;
    logic [FIFO_AW-1:0]     rd_ptr;
    logic [FIFO_AW:0]       count;
    logic [NBITS-1:0]       shift;
    logic [IW-1:0]          byte_idx;
    logic                   done_q;
    logic                   word_done_q;
    logic                   push;
    logic                   pop;

    // Push only when not full; pop only from IDLE, so no bypass path exists.
    assign word_ready = (count != FULL_CNT);
    assign push       = word_valid && word_ready;
    assign pop        = (state == IDLE) && (count != '0);

    assign uart_tx_start = (state == SEND);
    assign uart_tx_data  = shift[NBITS-1 -: BYTE_WIDTH];
    assign word_done     = word_done_q;
    assign busy          = (count != '0) || (state != IDLE);

    // FIFO storage: contents need no reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word_data;
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Byte sequencer. uart_tx_done is registered first and only captured in
    // WAIT, so a pulse landing in IDLE or SEND can never advance a byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shift       <= '0;
            byte_idx    <= '0;
            done_q      <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            word_done_q <= 1'b0;
            done_q      <= uart_tx_done && (state == WAIT);
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        shift    <= mem[rd_ptr];
                        byte_idx <= '0;
                        state    <= SEND;
                    end
                end
                SEND: state <= WAIT;
                WAIT: begin
                    if (done_q) begin
                        if (byte_idx == LAST_IDX) begin
                            word_done_q <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            shift    <= shift << BYTE_WIDTH;
                            byte_idx <= byte_idx + IW'(1);
                            state    <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_word_tx_sequencer.sv
// Bench for uart_word_tx_sequencer: timing vectors, stall/full corner
// sequences, reset mid-word, and a randomized run against a byte-queue model.
module tb_uart_word_tx_sequencer;
    localparam int NBITS = 32;
    localparam int BW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int NB    = NBITS / BW;

    logic             clk = 1'b0;
    logic             reset;
    logic             word_valid;
    logic [NBITS-1:0] word_data;
    logic             word_ready;
    logic [BW-1:0]    uart_tx_data;
    logic             uart_tx_start;
    logic             uart_tx_done;
    logic             word_done;
    logic             busy;

    uart_word_tx_sequencer #(
        .NBITS(NBITS), .BYTE_WIDTH(BW), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)
    ) dut (
        .clk(clk), .reset(reset),
        .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
        .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start),
        .uart_tx_done(uart_tx_done), .word_done(word_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NBITS-1:0] w;
        logic [NBITS-1:0] exp_bytes;
        int               delay;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
    int          start_log[$];
    int          wd_log[$];
    int          done_at = -1;
    bit          resp_en = 0;
    int          resp_delay = 3;
    int          n_starts = 0;
    int          n_wd = 0;
    int          n_acc = 0;
    logic        prev_start = 1'b0;
    logic [31:0] obs = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock; observe outputs after the edge, check bytes against the model,
    // and drive the UART responder's done pulse for this cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (!reset) begin
            if (uart_tx_start) begin
                chk("start_single_cycle", prev_start, 0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_start: got byte %0h expected no start", uart_tx_data);
                end else begin
                    chk("byte_order", uart_tx_data, exp_q.pop_front());
                end
                n_starts++;
                start_log.push_back(cyc);
                obs = {obs[23:0], uart_tx_data};
                if (resp_en) done_at = cyc + resp_delay;
            end
            if (word_done) begin
                n_wd++;
                wd_log.push_back(cyc);
            end
        end
        prev_start   = uart_tx_start;
        uart_tx_done = resp_en && (cyc == done_at);
    endtask

    task automatic offer(input logic [NBITS-1:0] w, output bit acc);
        word_valid = 1'b1;
        word_data  = w;
        acc        = word_ready;
        step();
        word_valid = 1'b0;
        if (acc) begin
            for (int b = 0; b < NB; b++) exp_q.push_back(w[NBITS-1-b*BW -: BW]);
            n_acc++;
        end
    endtask

    task automatic wait_wd(input int target, input int limit);
        int g = 0;
        while (n_wd < target && g < limit) begin
            step();
            g++;
        end
        chk("word_done_timeout", n_wd >= target, 1);
    endtask

    // Wait for a byte start, move into WAIT, then give one done pulse.
    task automatic pulse_after_start(input int target);
        int g = 0;
        while (n_starts < target && g < 100) begin
            step();
            g++;
        end
        chk("start_timeout", n_starts >= target, 1);
        step();
        uart_tx_done = 1'b1;
        step();
    endtask

    initial begin
        vec_t tbl[4];
        bit   acc;
        int   n0, s0, s1, wd0, acc0, g, outstanding;
        logic [NBITS-1:0] fw;

        tbl[0] = '{32'hDEADBEEF, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 3};
        tbl[1] = '{32'h11223344, {8'h11, 8'h22, 8'h33, 8'h44}, 1};
        tbl[2] = '{32'h00FF00FF, {8'h00, 8'hFF, 8'h00, 8'hFF}, 5};
        tbl[3] = '{32'hA5A55A5A, {8'hA5, 8'hA5, 8'h5A, 8'h5A}, 2};

        reset        = 1'b1;
        word_valid   = 1'b0;
        word_data    = '0;
        uart_tx_done = 1'b0;
        step();
        step();
        chk("rst_tx_data", uart_tx_data, 0);
        chk("rst_tx_start", uart_tx_start, 0);
        chk("rst_word_done", word_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_word_ready", word_ready, 1);
        reset = 1'b0;
        step();

        // Single words into an idle block: latency, byte gaps, word_done timing.
        foreach (tbl[i]) begin
            resp_en    = 1;
            resp_delay = tbl[i].delay;
            start_log.delete();
            wd_log.delete();
            obs = '0;
            n0  = cyc;
            wd0 = n_wd;
            offer(tbl[i].w, acc);
            chk("vec_accepted", acc, 1);
            wait_wd(wd0 + 1, 200);
            chk("vec_bytes", obs, tbl[i].exp_bytes);
            chk("vec_nstarts", start_log.size(), NB);
            if (start_log.size() == NB) begin
                chk("vec_first_start", start_log[0], n0 + 2);
                for (int k = 1; k < NB; k++)
                    chk("vec_byte_gap", start_log[k] - start_log[k-1], tbl[i].delay + 2);
                if (wd_log.size() > 0)
                    chk("vec_word_done_time", wd_log[0], start_log[NB-1] + tbl[i].delay + 2);
            end
            chk("vec_busy_after", busy, 0);
            step();
            chk("vec_word_done_pulse", word_done, 0);
        end

        // Stall: six offers with no done pulses; five fit (4 queued + 1 in flight).
        resp_en = 0;
        s0  = n_starts;
        wd0 = n_wd;
        for (int i = 0; i < 6; i++) begin
            fw = 32'h01020304 + 32'h10101010 * i;
            offer(fw, acc);
            chk("fill_ready", acc, (i < 5));
        end
        repeat (3) step();
        chk("fill_one_start", n_starts - s0, 1);
        chk("fill_ready_low", word_ready, 0);
        chk("fill_busy", busy, 1);
        for (int b = 0; b < NB; b++) pulse_after_start(s0 + b + 1);
        step();
        chk("full_pop_word_done", word_done, 1);
        chk("full_pop_ready", word_ready, 0);
        resp_en    = 1;
        resp_delay = 3;
        offer(32'hBAD0BAD0, acc);
        chk("full_pop_refused", acc, 0);
        chk("after_pop_ready", word_ready, 1);
        chk("after_pop_start", uart_tx_start, 1);
        wait_wd(wd0 + 5, 600);
        chk("stall_total_starts", n_starts - s0, 5 * NB);
        repeat (4) step();
        chk("stall_drained", exp_q.size(), 0);
        chk("stall_busy_low", busy, 0);

        // Done pulses in IDLE and SEND must not advance a byte.
        resp_en = 0;
        s0  = n_starts;
        wd0 = n_wd;
        uart_tx_done = 1'b1;
        step();
        chk("idle_done_nostart", uart_tx_start, 0);
        offer(32'hCAFEF00D, acc);
        uart_tx_done = 1'b1;
        step();
        chk("send_after_idle_done", uart_tx_start, 1);
        uart_tx_done = 1'b1;
        step();
        step();
        step();
        step();
        chk("send_done_ignored", n_starts - s0, 1);
        uart_tx_done = 1'b1;
        step();
        step();
        chk("wait_done_advances", uart_tx_start, 1);
        chk("wait_done_one_byte", n_starts - s0, 2);
        for (int b = 2; b <= NB; b++) pulse_after_start(s0 + b);
        wait_wd(wd0 + 1, 50);
        chk("idle_send_total", n_starts - s0, NB);

        // Reset in the middle of a word with more words queued.
        resp_en    = 1;
        resp_delay = 3;
        s0 = n_starts;
        offer(32'h11223344, acc);
        offer(32'h55667788, acc);
        offer(32'h99AABBCC, acc);
        g = 0;
        while (n_starts < s0 + 2 && g < 100) begin
            step();
            g++;
        end
        chk("rst2_reach_byte2", n_starts - s0, 2);
        step();
        reset = 1'b1;
        #1;
        chk("rst2_tx_data", uart_tx_data, 0);
        chk("rst2_tx_start", uart_tx_start, 0);
        chk("rst2_word_done", word_done, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_word_ready", word_ready, 1);
        exp_q.delete();
        done_at = -1;
        uart_tx_done = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst2_idle_after", busy, 0);
        s1  = n_starts;
        wd0 = n_wd;
        offer(32'hA5A5A5A5, acc);
        wait_wd(wd0 + 1, 100);
        repeat (10) step();
        chk("rst2_only_a5", n_starts - s1, NB);
        chk("rst2_model_empty", exp_q.size(), 0);

        // Randomized traffic and UART delays against the byte-queue model.
        resp_en = 1;
        acc0 = n_acc;
        wd0  = n_wd;
        for (int i = 0; i < 600; i++) begin
            outstanding = (n_acc - acc0) - (n_wd - wd0);
            chk("occupancy_bound", outstanding <= DEPTH + 1, 1);
            chk("full_means_occupied", word_ready || (outstanding >= DEPTH), 1);
            resp_delay = $urandom_range(1, 5);
            if ($urandom_range(0, 3) == 0) offer($urandom, acc);
            else step();
        end
        g = 0;
        while ((busy || exp_q.size() != 0) && g < 3000) begin
            step();
            g++;
        end
        chk("rand_drain_model", exp_q.size(), 0);
        chk("rand_drain_busy", busy, 0);
        chk("rand_word_count", n_wd - wd0, n_acc - acc0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
